// File: rtl/nmi_pkg.sv
// rtl/nmi_pkg.sv - shared types and defaults for native-memory-interface blocks
//
// Purpose: common widths, arbiter state encoding and the timeout read-data
// pattern used by the NMI interconnect blocks.
package nmi_pkg;

  localparam int NMI_ADDR_WIDTH  = 32;
  localparam int NMI_DATA_WIDTH  = 32;
  localparam int NMI_WSTRB_WIDTH = (NMI_DATA_WIDTH - 1) / 8 + 1;

  // Read data handed back when the slave never answers; easy to spot in a dump.
  localparam logic [31:0] NMI_TIMEOUT_RDATA = 32'hDEAD_BEEF;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/nmi_arbiter_rr_pick.sv
// rtl/nmi_arbiter_rr_pick.sv - combinational round-robin priority selector
//
// Purpose: returns the first asserted request found when searching upward
// from last_grant+1, wrapping modulo N.
// Ports:
//   req        in  N   request vector
//   last_grant in  IW  index granted most recently
//   idx        out IW  selected requester (0 when none)
//   any        out 1   at least one request is asserted
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int w_best;
  int w_dist;

  assign any = |req;

  // Each requester's distance past last_grant; the smallest distance wins,
  // so last_grant itself has the lowest priority (distance N-1).
  always_comb begin
    idx    = '0;
    w_best = N;
    w_dist = 0;
    for (int c = 0; c < N; c++) begin
      w_dist = (c + 2 * N - int'(last_grant) - 1) % N;
      if (req[c] && (w_dist < w_best)) begin
        w_best = w_dist;
        idx    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/nmi_arbiter.sv
// rtl/nmi_arbiter.sv - N-to-1 round-robin arbiter for the native memory interface
//
// Purpose: shares one downstream NMI slave between NUM_MASTERS masters. The
// grant is held for a whole transaction; a timer forces completion if the
// slave never answers.
// Ports:
//   clk, rstn                      clock, synchronous active-low reset
//   s_mem_valid/instr  in  N       per-master request and fetch flag
//   s_mem_addr/wdata/wstrb in      packed per-master fields (master i at slice i)
//   s_mem_ready        out N       per-master completion pulse
//   s_mem_rdata        out DW      read data broadcast to all masters
//   m_mem_*                        downstream NMI port
//   grant_idx          out IW      current / last granted master
//   timeout            out 1       pulse on forced completion
module nmi_arbiter
  import nmi_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = NMI_ADDR_WIDTH,
  parameter int DATA_WIDTH     = NMI_DATA_WIDTH,
  parameter int WSTRB_WIDTH    = (DATA_WIDTH - 1) / 8 + 1,
  parameter int TIMEOUT_CYCLES = 256,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_RDATA = DATA_WIDTH'(NMI_TIMEOUT_RDATA),
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [NUM_MASTERS-1:0]             s_mem_valid,
  output logic [NUM_MASTERS-1:0]             s_mem_ready,
  input  logic [NUM_MASTERS-1:0]             s_mem_instr,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]  s_mem_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]  s_mem_wdata,
  input  logic [NUM_MASTERS*WSTRB_WIDTH-1:0] s_mem_wstrb,
  output logic [DATA_WIDTH-1:0]              s_mem_rdata,
  output logic                               m_mem_valid,
  input  logic                               m_mem_ready,
  output logic                               m_mem_instr,
  output logic [ADDR_WIDTH-1:0]              m_mem_addr,
  output logic [DATA_WIDTH-1:0]              m_mem_wdata,
  output logic [WSTRB_WIDTH-1:0]             m_mem_wstrb,
  input  logic [DATA_WIDTH-1:0]              m_mem_rdata,
  output logic [IW-1:0]                      grant_idx,
  output logic                               timeout
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_t          r_state;
  logic [IW-1:0]       r_grant_idx;
  logic [IW-1:0]       r_last_grant;
  logic [TW-1:0]       r_timer;

  logic                w_busy;
  logic                w_done;
  logic                w_tmo;
  logic                w_finish;
  logic [IW-1:0]       w_pick_idx;
  logic                w_pick_any;
  logic [NUM_MASTERS-1:0] w_ready_oh;

  rr_pick #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_rr_pick (
    .req        (s_mem_valid),
    .last_grant (r_last_grant),
    .idx        (w_pick_idx),
    .any        (w_pick_any)
  );

  assign w_busy = (r_state == BUSY);

  // Downstream port follows the granted master combinationally while BUSY
  // and is forced to zero otherwise.
  assign m_mem_valid = w_busy & s_mem_valid[r_grant_idx];
  assign m_mem_instr = w_busy & s_mem_instr[r_grant_idx];
  assign m_mem_addr  = w_busy ? s_mem_addr[r_grant_idx*ADDR_WIDTH +: ADDR_WIDTH]    : '0;
  assign m_mem_wdata = w_busy ? s_mem_wdata[r_grant_idx*DATA_WIDTH +: DATA_WIDTH]   : '0;
  assign m_mem_wstrb = w_busy ? s_mem_wstrb[r_grant_idx*WSTRB_WIDTH +: WSTRB_WIDTH] : '0;

  assign w_done = m_mem_valid & m_mem_ready;

  // A real ready in the final timer cycle takes precedence over the timeout.
  assign w_tmo = (TIMEOUT_CYCLES != 0) && m_mem_valid && !m_mem_ready &&
                 (r_timer == TMO_LAST);

  // Any way out of BUSY: completion, timeout, or the master abandoning valid.
  assign w_finish = w_busy & (w_done | w_tmo | ~s_mem_valid[r_grant_idx]);

  always_comb begin
    w_ready_oh = '0;
    if (w_done || w_tmo) begin
      w_ready_oh[r_grant_idx] = 1'b1;
    end
  end

  assign s_mem_ready = w_ready_oh;
  assign s_mem_rdata = w_tmo ? TIMEOUT_RDATA : m_mem_rdata;
  assign timeout     = w_tmo;
  assign grant_idx   = r_grant_idx;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_grant_idx  <= '0;
      r_last_grant <= IW'(NUM_MASTERS - 1);
      r_timer      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_grant_idx <= w_pick_idx;
            r_timer     <= '0;
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          if (w_finish) begin
            // Updated on every exit, so a master that drops valid also
            // loses its priority.
            r_last_grant <= r_grant_idx;
            r_state      <= IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nmi_arbiter.sv
// tb/tb_nmi_arbiter.sv - directed table-driven bench for nmi_arbiter
module tb_nmi_arbiter;

  localparam logic [31:0] A0 = 32'h0000_0010;
  localparam logic [31:0] A1 = 32'h0000_0020;
  localparam logic [31:0] D0 = 32'h0BAD_F00D;
  localparam logic [31:0] D1 = 32'hA5A5_A5A5;
  localparam logic [3:0]  S0 = 4'h0;
  localparam logic [3:0]  S1 = 4'hF;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  s_mem_valid = '0;
  logic [1:0]  s_mem_ready;
  logic [1:0]  s_mem_instr = 2'b10;
  logic [63:0] s_mem_addr  = {A1, A0};
  logic [63:0] s_mem_wdata = {D1, D0};
  logic [7:0]  s_mem_wstrb = {S1, S0};
  logic [31:0] s_mem_rdata;
  logic        m_mem_valid;
  logic        m_mem_ready = 1'b0;
  logic        m_mem_instr;
  logic [31:0] m_mem_addr;
  logic [31:0] m_mem_wdata;
  logic [3:0]  m_mem_wstrb;
  logic [31:0] m_mem_rdata = '0;
  logic [0:0]  grant_idx;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nmi_arbiter #(
    .NUM_MASTERS    (2),
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .s_mem_valid (s_mem_valid),
    .s_mem_ready (s_mem_ready),
    .s_mem_instr (s_mem_instr),
    .s_mem_addr  (s_mem_addr),
    .s_mem_wdata (s_mem_wdata),
    .s_mem_wstrb (s_mem_wstrb),
    .s_mem_rdata (s_mem_rdata),
    .m_mem_valid (m_mem_valid),
    .m_mem_ready (m_mem_ready),
    .m_mem_instr (m_mem_instr),
    .m_mem_addr  (m_mem_addr),
    .m_mem_wdata (m_mem_wdata),
    .m_mem_wstrb (m_mem_wstrb),
    .m_mem_rdata (m_mem_rdata),
    .grant_idx   (grant_idx),
    .timeout     (timeout)
  );

  typedef struct {
    logic        rstn;
    logic [1:0]  v;
    logic        mr;
    logic [31:0] rd;
    logic        ev;
    logic [1:0]  er;
    logic        eg;
    logic        et;
    logic        eb;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic r, input logic [1:0] v, input logic mr,
                     input logic [31:0] rd, input logic ev, input logic [1:0] er,
                     input logic eg, input logic et, input logic eb);
    vec_t x;
    x.rstn = r; x.v = v; x.mr = mr; x.rd = rd;
    x.ev = ev; x.er = er; x.eg = eg; x.et = et; x.eb = eb;
    for (int k = 0; k < n; k++) tbl.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    logic        e_instr;
    int          cyc;
    bit          seen;

    // reset state, valid ignored while rstn low
    add(1, 0, 2'b11, 0, 32'h0,    0, 2'b00, 0, 0, 0);
    add(1, 1, 2'b00, 0, 32'h0,    0, 2'b00, 0, 0, 0);
    // single-master read
    add(1, 1, 2'b01, 0, 32'h0,    0, 2'b00, 0, 0, 0);
    add(1, 1, 2'b01, 0, 32'h0,    1, 2'b00, 0, 0, 1);
    add(1, 1, 2'b01, 1, 32'h1234, 1, 2'b01, 0, 0, 1);
    add(1, 1, 2'b00, 0, 32'h0,    0, 2'b00, 0, 0, 0);
    // contention, zero-wait slave: grants 1,0,1
    add(1, 1, 2'b11, 1, 32'h0,    0, 2'b00, 0, 0, 0);
    add(1, 1, 2'b11, 1, 32'h1111, 1, 2'b10, 1, 0, 1);
    add(1, 1, 2'b11, 1, 32'h0,    0, 2'b00, 1, 0, 0);
    add(1, 1, 2'b11, 1, 32'h2222, 1, 2'b01, 0, 0, 1);
    add(1, 1, 2'b11, 1, 32'h0,    0, 2'b00, 0, 0, 0);
    add(1, 1, 2'b11, 1, 32'h3333, 1, 2'b10, 1, 0, 1);
    // slave stall on master1 write
    add(1, 1, 2'b10, 0, 32'h0,    0, 2'b00, 1, 0, 0);
    add(5, 1, 2'b10, 0, 32'h0,    1, 2'b00, 1, 0, 1);
    add(1, 1, 2'b10, 1, 32'h4444, 1, 2'b10, 1, 0, 1);
    // timeout on 8th busy cycle, then next request served
    add(1, 1, 2'b01, 0, 32'h0,    0, 2'b00, 1, 0, 0);
    add(7, 1, 2'b01, 0, 32'h0,    1, 2'b00, 0, 0, 1);
    add(1, 1, 2'b01, 0, 32'h5555, 1, 2'b01, 0, 1, 1);
    add(1, 1, 2'b10, 0, 32'h0,    0, 2'b00, 0, 0, 0);
    add(1, 1, 2'b10, 1, 32'h6666, 1, 2'b10, 1, 0, 1);
    // ready in the final timer cycle beats the timeout
    add(1, 1, 2'b01, 0, 32'h0,    0, 2'b00, 1, 0, 0);
    add(7, 1, 2'b01, 0, 32'h0,    1, 2'b00, 0, 0, 1);
    add(1, 1, 2'b01, 1, 32'h7777, 1, 2'b01, 0, 0, 1);
    // master0 drops valid while master1 waits
    add(1, 1, 2'b10, 0, 32'h0,    0, 2'b00, 0, 0, 0);
    add(1, 1, 2'b10, 1, 32'h8888, 1, 2'b10, 1, 0, 1);
    add(1, 1, 2'b11, 0, 32'h0,    0, 2'b00, 1, 0, 0);
    add(1, 1, 2'b10, 0, 32'h0,    0, 2'b00, 0, 0, 1);
    add(1, 1, 2'b10, 0, 32'h0,    0, 2'b00, 0, 0, 0);
    add(1, 1, 2'b10, 1, 32'h9999, 1, 2'b10, 1, 0, 1);
    // reset while master1 is in flight
    add(1, 1, 2'b10, 0, 32'h0,    0, 2'b00, 1, 0, 0);
    add(1, 0, 2'b11, 0, 32'h0,    1, 2'b00, 1, 0, 1);
    add(1, 1, 2'b11, 1, 32'h0,    0, 2'b00, 0, 0, 0);
    add(1, 1, 2'b11, 1, 32'hAAAA, 1, 2'b01, 0, 0, 1);
    add(1, 1, 2'b00, 0, 32'h0,    0, 2'b00, 0, 0, 0);

    @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      #1;
      rstn        = tbl[i].rstn;
      s_mem_valid = tbl[i].v;
      m_mem_ready = tbl[i].mr;
      m_mem_rdata = tbl[i].rd;
      @(negedge clk);
      e_addr  = !tbl[i].eb ? 32'h0 : (tbl[i].eg ? A1 : A0);
      e_wdata = !tbl[i].eb ? 32'h0 : (tbl[i].eg ? D1 : D0);
      e_wstrb = !tbl[i].eb ? 4'h0  : (tbl[i].eg ? S1 : S0);
      e_instr = tbl[i].eb & tbl[i].eg;
      chk($sformatf("row%0d m_valid", i), 32'(m_mem_valid), 32'(tbl[i].ev));
      chk($sformatf("row%0d s_ready", i), 32'(s_mem_ready), 32'(tbl[i].er));
      chk($sformatf("row%0d grant", i),   32'(grant_idx),   32'(tbl[i].eg));
      chk($sformatf("row%0d timeout", i), 32'(timeout),     32'(tbl[i].et));
      chk($sformatf("row%0d m_addr", i),  m_mem_addr,       e_addr);
      chk($sformatf("row%0d m_wdata", i), m_mem_wdata,      e_wdata);
      chk($sformatf("row%0d m_wstrb", i), 32'(m_mem_wstrb), 32'(e_wstrb));
      chk($sformatf("row%0d m_instr", i), 32'(m_mem_instr), 32'(e_instr));
      if (tbl[i].er != 2'b00)
        chk($sformatf("row%0d s_rdata", i), s_mem_rdata,
            tbl[i].et ? 32'hDEAD_BEEF : tbl[i].rd);
      @(posedge clk);
    end

    // hand sequence: master1 alone against a dead slave; forced completion
    // must land on cycle 9 (one arbitration cycle plus eight BUSY cycles)
    #1;
    s_mem_valid = 2'b10;
    m_mem_ready = 1'b0;
    m_mem_rdata = 32'h0;
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (s_mem_ready != 2'b00) begin
        seen = 1;
        chk("tmo_seq ready_bits", 32'(s_mem_ready), 32'h2);
        chk("tmo_seq timeout",    32'(timeout),     32'h1);
        chk("tmo_seq rdata",      s_mem_rdata,      32'hDEAD_BEEF);
        chk("tmo_seq latency",    32'(cyc),         32'd9);
      end else begin
        chk("tmo_seq no_early_timeout", 32'(timeout), 32'h0);
      end
      @(posedge clk);
      #1;
    end
    if (!seen) chk("tmo_seq ready_seen", 32'h0, 32'h1);
    s_mem_valid = 2'b00;
    @(negedge clk);
    chk("tmo_seq back_to_idle", 32'(m_mem_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
